soc_event_queue: RTL
====================

// Module: soc_event_queue
// PURPOSE
// Collects single-cycle uDMA/peripheral event strobes (the 31*4-bit udma events vector) and serialises
// them into event IDs. The IDs feed the host-side event consumer (CVA6 event/IRQ path) through a FIFO.
// - Sits directly downstream of apb_subsystem events_o, in the s_soc_clk domain.
// - Simultaneous strobes are never merged silently: every strobe yields one ID, or raises the sticky lost flag.
// PARAMETERS
// NUM_EVT   124  number of event input lines
// DEPTH     8    FIFO entries; power of two, >=2
// ID_W      $clog2(NUM_EVT)  event ID width (derived, do not override)
// CNT_W     $clog2(DEPTH+1)  occupancy width (derived)
// PORTS
// clk_i        in   1        SoC clock
// rst_i        in   1        asynchronous reset, active-high
// evt_i        in   NUM_EVT  event strobes; each cycle a bit is 1 counts as one event
// irq_en_i     in   1        enables irq_o
// lost_clr_i   in   1        clears lost_o and lost_id_o
// evt_valid_o  out  1        FIFO head valid
// evt_id_o     out  ID_W     FIFO head event ID (index of evt_i bit)
// evt_ready_i  in   1        consumer pop; pop occurs when valid&ready
// count_o      out  CNT_W    FIFO occupancy
// irq_o        out  1        registered: irq_en_i & (FIFO non-empty)
// lost_o       out  1        sticky: an event was dropped
// lost_id_o    out  ID_W     ID of the first dropped event since last clear
// BEHAVIOUR
// - Reset (async, rst_i=1): pending=0, rr_ptr=0, FIFO empty, evt_valid_o=0, evt_id_o=0, count_o=0, irq_o=0,
//   lost_o=0, lost_id_o=0.
// - Pending stage: pending[i] is set at the clock edge when evt_i[i]=1.
//   - If pending[i] is already 1 and is not granted that cycle, the strobe is dropped.
//   - On a drop, lost_o<=1; lost_id_o<=i only if lost_o was 0 (lowest i wins among simultaneous drops).
//   - Grant and a new strobe on the same bit in the same cycle: pending[i] stays 1, no drop.
// - Arbiter: round-robin over the pending bits, searching upward from rr_ptr with wrap at NUM_EVT-1 -> 0.
//   - One grant per cycle, only when the FIFO can accept: count<DEPTH, or count==DEPTH with a pop this cycle.
//   - On grant g: push ID g, clear pending[g], rr_ptr<=(g+1) mod NUM_EVT.
//   - No grant: rr_ptr holds.
// - FIFO: DEPTH entries, wr/rd pointers wrap modulo DEPTH.
//   - Push and pop in the same cycle leave count unchanged (legal when full or empty+1).
//   - Pop while empty is ignored.
//   - evt_id_o/evt_valid_o driven from registered head state; no combinational path from evt_i.
//   - evt_id_o holds its value while evt_valid_o=1 and evt_ready_i=0.
// - Latency: evt_i[k]=1 in cycle N with idle queue -> pending at N+1, pushed at end of N+1,
//   evt_valid_o=1 with evt_id_o=k in cycle N+2. Sustained throughput is 1 ID/cycle.
// - irq_o <= irq_en_i & (next count != 0); asserts in the same cycle as evt_valid_o.
// - lost_clr_i has priority over a drop in the same cycle: the flag clears, and that cycle's drop is not recorded.
// - Backpressure: a full FIFO stalls grants; pending absorbs one event per line, further strobes drop.
// TESTING
// 1. Reset mid-operation: 3 entries queued, pulse rst_i asynchronously -> all outputs 0 immediately;
//    no stale ID after release.
// 2. Single event, latency: evt_i[5] pulses at cycle 10, ready=1 -> valid=1, id=5 at cycle 12,
//    count 0->1->0, irq_o=1 for one cycle.
// 3. Round-robin: evt_i bits {3,7,120} pulse together, rr_ptr=0 -> IDs 3,7,120 on consecutive cycles;
//    next burst {3,7} after last grant=120 -> order 3,7.
// 4. Full FIFO and drop: ready=0, DEPTH=8, strobe bits 0..8 once -> count=8, pending[8]=1; strobe bit 8 again
//    -> lost_o=1, lost_id_o=8; then ready=1 drains IDs 0..8 in order.
// 5. Full with simultaneous push/pop: count=8, ready=1, new strobe -> count stays 8, no drop, order preserved.
// 6. Grant/strobe collision and clear: bit 2 pending and granted while evt_i[2]=1 -> two ID-2 entries, lost_o=0;
//    drop and lost_clr_i in same cycle -> lost_o=0.

Source files
------------

// File: rtl/soc_event_queue_if.sv
// Consumer-side handshake of the event queue: head ID/valid out, pop-ready in.
interface soc_event_queue_if #(
    parameter int ID_W = 7
);
    logic            evt_valid_o;
    logic [ID_W-1:0] evt_id_o;
    logic            evt_ready_i;

    modport master (output evt_valid_o, output evt_id_o, input evt_ready_i);
    modport slave  (input evt_valid_o, input evt_id_o, output evt_ready_i);
endinterface

// File: rtl/soc_event_queue.sv
// Serialises single-cycle event strobes into event IDs via a per-line pending bit,
// a round-robin arbiter and a small FIFO; dropped strobes raise a sticky lost flag.
module soc_event_queue #(
    parameter  int NUM_EVT = 124,
    parameter  int DEPTH   = 8,
    localparam int ID_W    = $clog2(NUM_EVT),
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NUM_EVT-1:0]   evt_i,
    input  logic                 irq_en_i,
    input  logic                 lost_clr_i,
    soc_event_queue_if.master    evt_if,
    output logic [CNT_W-1:0]     count_o,
    output logic                 irq_o,
    output logic                 lost_o,
    output logic [ID_W-1:0]      lost_id_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [NUM_EVT-1:0] pend_q, pend_d;
    logic [NUM_EVT-1:0] gnt_mask, drop;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]    gnt_id, drop_id;
    logic               gnt_vld, grant, pop, drop_any;
    logic [ID_W-1:0]    mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               irq_q, lost_q;
    logic [ID_W-1:0]    lost_id_q;

    assign pop = (count_q != '0) && evt_if.evt_ready_i;

    // Rotating-priority search: first pending bit at or above rr_ptr, wrapping to 0.
    always_comb begin : arb
        int idx;
        idx     = 0;
        gnt_vld = 1'b0;
        gnt_id  = '0;
        for (int k = 0; k < NUM_EVT; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_EVT) idx = idx - NUM_EVT;
            if (!gnt_vld && pend_q[idx]) begin
                gnt_vld = 1'b1;
                gnt_id  = ID_W'(idx);
            end
        end
    end

    assign grant = gnt_vld && ((count_q < CNT_W'(DEPTH)) || pop);

    always_comb begin
        gnt_mask = '0;
        if (grant) gnt_mask[gnt_id] = 1'b1;
        drop     = evt_i & pend_q & ~gnt_mask;
        drop_any = |drop;
        pend_d   = (pend_q & ~gnt_mask) | evt_i;
        drop_id  = '0;
        for (int i = NUM_EVT - 1; i >= 0; i--) begin
            if (drop[i]) drop_id = ID_W'(i);
        end
        rr_ptr_d = rr_ptr_q;
        if (grant) rr_ptr_d = (gnt_id == ID_W'(NUM_EVT - 1)) ? '0 : gnt_id + 1'b1;
        count_d = count_q;
        if (grant && !pop)      count_d = count_q + 1'b1;
        else if (!grant && pop) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_q    <= '0;
            rr_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            irq_q     <= 1'b0;
            lost_q    <= 1'b0;
            lost_id_q <= '0;
        end else begin
            pend_q   <= pend_d;
            rr_ptr_q <= rr_ptr_d;
            count_q  <= count_d;
            irq_q    <= irq_en_i && (count_d != '0);
            if (grant) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
            // A clear in the same cycle as a drop wins; that drop is forgotten.
            if (lost_clr_i) begin
                lost_q    <= 1'b0;
                lost_id_q <= '0;
            end else if (drop_any && !lost_q) begin
                lost_q    <= 1'b1;
                lost_id_q <= drop_id;
            end
        end
    end

    // Storage is not reset; the head is masked while the queue is empty.
    always_ff @(posedge clk_i) begin
        if (grant) mem_q[wr_ptr_q] <= gnt_id;
    end

    assign evt_if.evt_valid_o = (count_q != '0);
    assign evt_if.evt_id_o    = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count_o            = count_q;
    assign irq_o              = irq_q;
    assign lost_o             = lost_q;
    assign lost_id_o          = lost_id_q;
endmodule
